// File: rtl/dct_mac_sequencer.sv
// rtl/dct_mac_sequencer.sv - tap sequencer and result handshake for one DCT macu
module dct_mac_sequencer #(
  parameter int N_TAPS  = 8,
  parameter int MAC_LAT = 2,
  parameter int ROW_W   = 3,
  localparam int TAP_W  = $clog2(N_TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   start,
  input  logic [ROW_W-1:0]       row_sel,
  output logic                   start_ready,
  output logic                   mac_clr,
  output logic                   mac_ena,
  output logic [TAP_W-1:0]       samp_idx,
  output logic [ROW_W+TAP_W-1:0] coef_idx,
  output logic                   result_ld,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_LOAD,
    S_HOLD
  } state_t;

  localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(N_TAPS - 1);
  // Only meaningful when MAC_LAT > 0; DRAIN is unreachable otherwise.
  localparam logic [2:0]       DRAIN_LAST = 3'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  state_t           state_q;
  state_t           state_d;
  logic [TAP_W-1:0] tap_q;
  logic [2:0]       drain_q;
  logic [ROW_W-1:0] row_q;
  logic [TAP_W-1:0] idx_q;
  logic             accept;

  // State register; reset aborts any run in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded controls; ena gates every strobe toward the MAC.
  always_comb begin
    state_d     = state_q;
    mac_ena     = 1'b0;
    mac_clr     = 1'b0;
    result_ld   = 1'b0;
    start_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (ena && start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mac_ena = ena;
        mac_clr = ena && (tap_q == '0);
        if (ena && (tap_q == TAP_LAST)) begin
          state_d = (MAC_LAT > 0) ? S_DRAIN : S_LOAD;
        end
      end
      S_DRAIN: begin
        if (ena && (drain_q == DRAIN_LAST)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        result_ld = ena;
        if (ena) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        start_ready = res_ready;
        if (ena && res_ready) begin
          state_d = start ? S_RUN : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    accept = ena && start && start_ready;
  end

  // Tap/drain counters, latched row and last issued tap index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q   <= '0;
      drain_q <= '0;
      row_q   <= '0;
      idx_q   <= '0;
    end else if (ena) begin
      if (accept) begin
        row_q <= row_sel;
      end
      if (state_q == S_RUN) begin
        idx_q <= tap_q;
        tap_q <= (tap_q == TAP_LAST) ? '0 : tap_q + TAP_W'(1);
      end
      if (state_q == S_DRAIN) begin
        drain_q <= (drain_q == DRAIN_LAST) ? 3'd0 : drain_q + 3'd1;
      end
    end
  end

  // Outside RUN the address lines keep showing the last tap that was issued.
  assign samp_idx  = (state_q == S_RUN) ? tap_q : idx_q;
  assign coef_idx  = {row_q, samp_idx};
  assign res_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// tb/tb_dct_mac_sequencer.sv - directed and random checks of dct_mac_sequencer
module tb_dct_mac_sequencer;

  localparam int N  = 8;
  localparam int L  = 2;
  localparam int RW = 3;
  localparam int TW = 3;

  logic          clk;
  logic          rst;
  logic          ena;
  logic          start;
  logic [RW-1:0] row_sel;
  logic          start_ready;
  logic          mac_clr;
  logic          mac_ena;
  logic [TW-1:0] samp_idx;
  logic [RW+TW-1:0] coef_idx;
  logic          result_ld;
  logic          res_valid;
  logic          res_ready;
  logic          busy;

  dct_mac_sequencer #(.N_TAPS(N), .MAC_LAT(L), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .row_sel(row_sel),
    .start_ready(start_ready), .mac_clr(mac_clr), .mac_ena(mac_ena),
    .samp_idx(samp_idx), .coef_idx(coef_idx), .result_ld(result_ld),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: enabled cycles elapsed since the accepting edge.
  bit m_active;
  int m_k;
  int m_row;
  int m_last;

  int cyc;
  int mac_cnt;
  int ld_cnt;
  int ld_cyc;
  int valid_cnt;
  logic          o_clr;
  logic [RW+TW-1:0] o_coef;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    mac_cnt = 0;
    ld_cnt = 0;
    ld_cyc = -1;
    valid_cnt = 0;
    cyc = 0;
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic [RW-1:0] rs, input logic rr);
    bit run, ld, hold;
    int samp;
    int rdy;
    @(negedge clk);
    rst = r; ena = e; start = s; row_sel = rs; res_ready = rr;
    if (r) begin
      m_active = 0; m_k = 0; m_row = 0; m_last = 0;
    end
    #1;
    run  = m_active && m_k >= 1 && m_k <= N;
    ld   = m_active && m_k == N + L + 1;
    hold = m_active && m_k >= N + L + 2;
    samp = run ? m_k - 1 : m_last;
    rdy  = !m_active ? 1 : (hold ? int'(rr) : 0);
    chk("mac_ena",     32'(mac_ena),     32'(run && e));
    chk("mac_clr",     32'(mac_clr),     32'(run && e && m_k == 1));
    chk("result_ld",   32'(result_ld),   32'(ld && e));
    chk("res_valid",   32'(res_valid),   32'(hold));
    chk("busy",        32'(busy),        32'(m_active));
    chk("start_ready", 32'(start_ready), 32'(rdy));
    chk("samp_idx",    32'(samp_idx),    32'(samp));
    chk("coef_idx",    32'(coef_idx),    32'(m_row * N + samp));
    if (mac_ena) mac_cnt++;
    if (result_ld) begin ld_cnt++; ld_cyc = cyc; end
    if (res_valid) valid_cnt++;
    o_clr = mac_clr;
    o_coef = coef_idx;
    if (!r && e) begin
      if (run) m_last = m_k - 1;
      if (hold) begin
        if (rr) begin
          if (s) begin m_k = 1; m_row = int'(rs); end
          else m_active = 0;
        end
      end else if (!m_active) begin
        if (s) begin m_active = 1; m_k = 1; m_row = int'(rs); end
      end else begin
        m_k++;
      end
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; start = 1'b0; row_sel = '0; res_ready = 1'b0;
    m_active = 0; m_k = 0; m_row = 0; m_last = 0;
    clr_stats();

    // Reset state
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 3, 1);

    // Single run, row 5, consumed at cycle 12
    step(0, 1, 0, 0, 0);
    clr_stats();
    step(0, 1, 1, 5, 0);
    for (int i = 1; i <= 14; i++) step(0, 1, 0, 3'(i), i >= 12);
    chk("single_mac_cnt", 32'(mac_cnt), 32'(8));
    chk("single_ld_cyc", 32'(ld_cyc), 32'(11));
    chk("single_valid_cnt", 32'(valid_cnt), 32'(1));

    // Back-pressure with ignored start pulses
    clr_stats();
    step(0, 1, 1, 6, 0);
    for (int i = 1; i <= 33; i++) step(0, 1, (i % 2 == 1) && i != 32, 3'(7 - (i % 8)), i == 32);
    chk("bp_valid_cnt", 32'(valid_cnt), 32'(21));
    chk("bp_mac_cnt", 32'(mac_cnt), 32'(8));
    chk("bp_ld_cnt", 32'(ld_cnt), 32'(1));

    // Back-to-back accept in HOLD
    clr_stats();
    step(0, 1, 1, 1, 0);
    for (int i = 1; i <= 11; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 2, 1);
    step(0, 1, 0, 4, 1);
    chk("b2b_clr", 32'(o_clr), 32'(1));
    chk("b2b_coef", 32'(o_coef), 32'(16));
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 1);

    // Three-cycle ena stall at tap 4
    clr_stats();
    step(0, 1, 1, 3, 1);
    for (int i = 1; i <= 20; i++) step(0, !(i >= 5 && i <= 7), 1'b0, 0, 1);
    chk("stall_mac_cnt", 32'(mac_cnt), 32'(8));
    chk("stall_ld_cyc", 32'(ld_cyc), 32'(14));

    // Async reset while tap 3 is on the bus
    step(0, 1, 1, 7, 1);
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 0, 1);
    clr_stats();
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 1);
    chk("rst_no_ld", 32'(ld_cnt), 32'(0));

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dct_mac_sequencer.md
Name: dct_mac_sequencer

Overview:
- Controls one DCT multiply-accumulate unit (dct_unit/macu) inside a dct_block of the fdct stage.
- On each accepted start it steps the MAC through N_TAPS sample/coefficient pairs, clearing the accumulator on the first tap.
- It waits out the multiplier pipeline, then pulses the load enable of the macu result register.
- It holds a valid/ready result handshake toward the zig-zag/quantiser side until the result is consumed.

Parameters:
N_TAPS, 8, number of MAC terms per result; power of two, 2..16
MAC_LAT, 2, multiplier/accumulator pipeline depth in cycles between the last mac_ena and a stable accumulator; 0..7
ROW_W, 3, width of coefficient row select

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
ena  in  1  global clock enable; 0 freezes all state
start  in  1  request to compute one result
row_sel  in  ROW_W  coefficient row for this result; sampled on accept
start_ready  out  1  start is accepted when start & start_ready & ena
mac_clr  out  1  accumulator loads product instead of adding (first tap)
mac_ena  out  1  MAC accumulate enable
samp_idx  out  log2(N_TAPS)  sample index to MAC input mux
coef_idx  out  ROW_W+log2(N_TAPS)  coefficient ROM address = {row, tap}
result_ld  out  1  one-cycle enable of macu result register (DFFE enable)
res_valid  out  1  result register holds an unconsumed result
res_ready  in  1  downstream consumes result when res_valid & res_ready & ena
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, tap/drain counters=0, row register=0. Outputs: mac_clr=0, mac_ena=0, samp_idx=0, coef_idx=0, result_ld=0, res_valid=0, busy=0, start_ready=1. An assertion mid-operation aborts immediately; no result_ld is issued.
- States: IDLE, RUN, DRAIN, LOAD, HOLD.
- IDLE: start_ready=1. On accept, latch row_sel and go to RUN with tap=0.
- RUN: mac_ena=1, samp_idx=tap, coef_idx={row,tap}, mac_clr=(tap==0).
  - tap increments each enabled cycle.
  - At tap==N_TAPS-1, go to DRAIN if MAC_LAT>0, else to LOAD.
  - Exactly N_TAPS mac_ena cycles per result.
- DRAIN: mac_ena=0. Counts MAC_LAT enabled cycles, then goes to LOAD.
- LOAD: result_ld=1 for exactly one enabled cycle, then go to HOLD.
- HOLD: res_valid=1 and start_ready=res_ready.
  - On consume with a simultaneous accepted start: latch row_sel and go to RUN (back-to-back, no idle bubble).
  - On consume without start: go to IDLE.
  - No consume: stay in HOLD; outputs stable.
- Latency: accept in cycle T → RUN cycles T+1..T+N_TAPS → LOAD at T+N_TAPS+MAC_LAT+1 → res_valid first high at T+N_TAPS+MAC_LAT+2.
- ena=0: state, counters and row register hold. mac_ena, mac_clr and result_ld are forced 0. res_valid, busy, samp_idx and coef_idx hold their values. start and res_ready are ignored.
- start in RUN/DRAIN/LOAD (start_ready=0) is ignored and not queued.
- row_sel changes after accept have no effect on the current result.
- Counter wrap: tap wraps to 0 on leaving RUN; no counter may exceed its terminal value.
- samp_idx/coef_idx outside RUN hold the last issued value (tap N_TAPS-1), except after reset (0).
- All outputs are registered or decoded from state only; there is no combinational path from start/res_ready to mac_* or result_ld.
- start_ready in HOLD is the only combinational path (res_ready → start_ready).

Test Plan:
- Reset then single run (N_TAPS=8, MAC_LAT=2, row_sel=5, accept at cycle 0, res_ready=1 from cycle 12) → mac_ena high cycles 1–8; mac_clr only cycle 1; coef_idx 40..47; result_ld cycle 11; res_valid cycles 12 only; returns to IDLE.
- Back-pressure: res_ready=0 for 20 cycles after LOAD → res_valid held high, mac_ena=0, start pulses ignored; consume at cycle 32 → res_valid falls at cycle 33.
- Back-to-back: start=1 with row_sel=2 in the cycle res_ready=1 in HOLD → next cycle RUN with mac_clr=1 and coef_idx=16; no IDLE cycle.
- ena stall: ena=0 for 3 cycles at tap=4 → tap, samp_idx and coef_idx frozen, mac_ena=0; resume yields 8 total mac_ena cycles and result_ld delayed by exactly 3 cycles.
- Async reset mid-RUN (tap=3) → all outputs at reset values in the same cycle; no result_ld before the next accepted start.
- MAC_LAT=0 build → result_ld immediately follows the last RUN cycle; res_valid at T+N_TAPS+2.
